// File: rtl/hazard_pkg.sv
// Shared types and field offsets for the hazard/forwarding controller.
package hazard_pkg;

    // Registered stall reason reported on hz_state.
    typedef enum logic [1:0] {
        HZ_IDLE    = 2'd0,
        HZ_DATA    = 2'd1,
        HZ_MD_WAIT = 2'd2
    } hz_state_t;

    // EX operand source selects.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Bit offsets above the RW-bit dest field in the *_wr bundles:
    // bit RW+WR_EN_OFS is regwrite, bit RW+WR_FLAG_OFS is memread (EX) / memtoreg (MEM).
    localparam int WR_EN_OFS   = 0;
    localparam int WR_FLAG_OFS = 1;

    // Bit positions inside id_ctrl.
    localparam int CTRL_USES_RS = 0;
    localparam int CTRL_USES_RT = 1;
    localparam int CTRL_BRANCH  = 2;
    localparam int CTRL_MD_ISSUE = 3;

endpackage

// File: rtl/md_scoreboard.sv
// Busy-bit scoreboard for the fixed-latency MUL/DIV unit. Only one op is in
// flight at a time; its dest bit clears on the edge that writes the RF.
module md_scoreboard #(
    parameter int RW         = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_i,
    input  logic [RW-1:0] issue_dest_i,
    input  logic [RW-1:0] rs_i,
    input  logic [RW-1:0] rt_i,
    output logic          rs_busy_o,
    output logic          rt_busy_o,
    output logic          md_busy_o
);

    localparam int LW = $clog2(MD_LATENCY + 1);
    localparam logic [LW-1:0] CNT_ONE  = LW'(1);
    localparam logic [LW-1:0] CNT_LOAD = LW'(MD_LATENCY);

    logic [LW-1:0]      md_cnt_q, md_cnt_d;
    logic [RW-1:0]      md_dest_q, md_dest_d;
    logic [2**RW-1:0]   busy_q, busy_d;

    // Count down the in-flight op, clear its busy bit on the 1->0 edge, load on issue.
    always_comb begin
        md_cnt_d  = md_cnt_q;
        md_dest_d = md_dest_q;
        busy_d    = busy_q;
        if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_ONE;
            if (md_cnt_q == CNT_ONE) begin
                busy_d[md_dest_q] = 1'b0;
            end
        end
        if (issue_i) begin
            md_cnt_d             = CNT_LOAD;
            md_dest_d            = issue_dest_i;
            busy_d[issue_dest_i] = 1'b1;
        end
    end

    // Scoreboard state; reset forgets any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q  <= '0;
            md_dest_q <= '0;
            busy_q    <= '0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            md_dest_q <= md_dest_d;
            busy_q    <= busy_d;
        end
    end

    assign rs_busy_o = busy_q[rs_i];
    assign rt_busy_o = busy_q[rt_i];
    assign md_busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: ID-time compare of
// sources against EX/MEM/WB writers, MUL/DIV scoreboard, stall-reason FSM and
// a sticky stall watchdog.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int RW         = 5,
    parameter int MD_LATENCY = 4,
    parameter int MAX_STALL  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [2*RW-1:0] id_srcs,
    input  logic [3:0]      id_ctrl,
    input  logic [RW:0]     id_wr,
    input  logic [RW+1:0]   ex_wr,
    input  logic [RW+1:0]   mem_wr,
    input  logic [RW:0]     wb_wr,
    input  logic            flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            fwd_c,
    output logic            fwd_d,
    output logic [1:0]      rf_bypass,
    output logic            stall,
    output logic            id_noop,
    output logic            md_busy,
    output logic [1:0]      hz_state,
    output logic            stall_err
);

    localparam int CW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [RW-1:0] id_rs, id_rt, id_dest, ex_dest, mem_dest, wb_dest;
    logic uses_rs, uses_rt, branch, md_issue;
    logic ex_rw, ex_memread, mem_rw, mem_memtoreg, wb_rw;
    logic rs_live, rt_live, rs_ex, rt_ex, rs_mem, rt_mem;
    logic rs_busy, rt_busy;
    logic data_hz, md_hz, accept, md_accept;

    logic [1:0]    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    hz_state_t     state_q, state_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          stall_err_q, stall_err_d;

    assign id_rs        = id_srcs[RW-1:0];
    assign id_rt        = id_srcs[2*RW-1:RW];
    assign id_dest      = id_wr[RW-1:0];
    assign ex_dest      = ex_wr[RW-1:0];
    assign mem_dest     = mem_wr[RW-1:0];
    assign wb_dest      = wb_wr[RW-1:0];
    assign uses_rs      = id_ctrl[CTRL_USES_RS];
    assign uses_rt      = id_ctrl[CTRL_USES_RT];
    assign branch       = id_ctrl[CTRL_BRANCH];
    assign md_issue     = id_ctrl[CTRL_MD_ISSUE];
    assign ex_rw        = ex_wr[RW+WR_EN_OFS];
    assign ex_memread   = ex_wr[RW+WR_FLAG_OFS];
    assign mem_rw       = mem_wr[RW+WR_EN_OFS];
    assign mem_memtoreg = mem_wr[RW+WR_FLAG_OFS];
    assign wb_rw        = wb_wr[RW+WR_EN_OFS];

    // r0 is never a hazard source.
    assign rs_live = uses_rs & (id_rs != '0);
    assign rt_live = uses_rt & (id_rt != '0);
    assign rs_ex   = rs_live & ex_rw  & (id_rs == ex_dest);
    assign rt_ex   = rt_live & ex_rw  & (id_rt == ex_dest);
    assign rs_mem  = rs_live & mem_rw & (id_rs == mem_dest);
    assign rt_mem  = rt_live & mem_rw & (id_rt == mem_dest);

    // A branch behind an EX load stalls twice: once here on the EX match,
    // then again on the MEM-load match.
    assign data_hz = ((rs_ex | rt_ex) & (ex_memread | branch))
                   | (branch & mem_memtoreg & (rs_mem | rt_mem));
    assign md_hz   = (rs_live & rs_busy) | (rt_live & rt_busy) | (md_issue & md_busy);

    assign stall     = (data_hz | md_hz) & id_valid & ~flush;
    assign id_noop   = stall | flush;
    assign accept    = id_valid & ~stall & ~flush;
    assign md_accept = accept & md_issue & id_wr[RW] & (id_dest != '0);

    assign fwd_c        = branch & ~mem_memtoreg & rs_mem;
    assign fwd_d        = branch & ~mem_memtoreg & rt_mem;
    assign rf_bypass[0] = wb_rw & (wb_dest != '0) & (wb_dest == id_rs);
    assign rf_bypass[1] = wb_rw & (wb_dest != '0) & (wb_dest == id_rt);

    md_scoreboard #(
        .RW         (RW),
        .MD_LATENCY (MD_LATENCY)
    ) u_md_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_i      (md_accept),
        .issue_dest_i (id_dest),
        .rs_i         (id_rs),
        .rt_i         (id_rt),
        .rs_busy_o    (rs_busy),
        .rt_busy_o    (rt_busy),
        .md_busy_o    (md_busy)
    );

    // Next EX forwarding selects; anything not accepted enters EX as a bubble.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (accept) begin
            if (rs_ex & ~ex_memread) fwd_a_d = FWD_MEM;
            else if (rs_mem)         fwd_a_d = FWD_WB;
            if (rt_ex & ~ex_memread) fwd_b_d = FWD_MEM;
            else if (rt_mem)         fwd_b_d = FWD_WB;
        end
    end

    // Stall-reason FSM next state; data hazards take priority over MD waits.
    always_comb begin
        state_d = HZ_IDLE;
        if (stall) begin
            state_d = data_hz ? HZ_DATA : HZ_MD_WAIT;
        end
    end

    // Watchdog: saturating run length of consecutive stalls, sticky error at the limit.
    always_comb begin
        stall_cnt_d = '0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
        end
        stall_err_d = stall_err_q | (stall_cnt_d == CNT_MAX);
    end

    // Registered forwarding selects, FSM state and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            state_q     <= HZ_IDLE;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign hz_state  = state_q;
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed pipeline scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of the hazard rules.
module tb_hazard_scoreboard_unit;

    localparam int RW   = 5;
    localparam int MDL  = 4;
    localparam int MAXS = 3;

    localparam logic [3:0] C_RS = 4'b0001;
    localparam logic [3:0] C_RT = 4'b0010;
    localparam logic [3:0] C_BR = 4'b0100;
    localparam logic [3:0] C_MD = 4'b1000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            id_valid;
    logic [2*RW-1:0] id_srcs;
    logic [3:0]      id_ctrl;
    logic [RW:0]     id_wr;
    logic [RW+1:0]   ex_wr, mem_wr;
    logic [RW:0]     wb_wr;
    logic            flush;
    logic [1:0]      fwd_a, fwd_b, rf_bypass, hz_state;
    logic            fwd_c, fwd_d, stall, id_noop, md_busy, stall_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.RW(RW), .MD_LATENCY(MDL), .MAX_STALL(MAXS)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_srcs(id_srcs),
        .id_ctrl(id_ctrl), .id_wr(id_wr), .ex_wr(ex_wr), .mem_wr(mem_wr),
        .wb_wr(wb_wr), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_c(fwd_c), .fwd_d(fwd_d), .rf_bypass(rf_bypass), .stall(stall),
        .id_noop(id_noop), .md_busy(md_busy), .hz_state(hz_state),
        .stall_err(stall_err)
    );

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // MD op modelled as "cycles left until the RF write" plus its dest register.
    int m_left, m_dest, m_fa, m_fb, m_hz, m_run;
    bit m_err;

    int s_src[2];
    bit s_used[2], s_exh[2], s_memh[2];
    bit e_data, e_md, e_stall, e_noop, e_c, e_d, e_acc;
    logic [1:0] e_byp;

    always_comb begin
        s_src[0]  = int'(id_srcs[RW-1:0]);
        s_src[1]  = int'(id_srcs[2*RW-1:RW]);
        s_used[0] = id_ctrl[0];
        s_used[1] = id_ctrl[1];
        e_data = 1'b0;
        e_md   = id_ctrl[3] && (m_left > 0);
        e_byp  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            s_exh[i]  = s_used[i] && s_src[i] != 0 && ex_wr[RW] && s_src[i] == int'(ex_wr[RW-1:0]);
            s_memh[i] = s_used[i] && s_src[i] != 0 && mem_wr[RW] && s_src[i] == int'(mem_wr[RW-1:0]);
            if (s_exh[i] && (ex_wr[RW+1] || id_ctrl[2])) e_data = 1'b1;
            if (s_memh[i] && id_ctrl[2] && mem_wr[RW+1]) e_data = 1'b1;
            if (s_used[i] && s_src[i] != 0 && m_left > 0 && m_dest == s_src[i]) e_md = 1'b1;
            if (wb_wr[RW] && wb_wr[RW-1:0] != '0 && int'(wb_wr[RW-1:0]) == s_src[i]) e_byp[i] = 1'b1;
        end
        e_c     = id_ctrl[2] && s_memh[0] && !mem_wr[RW+1];
        e_d     = id_ctrl[2] && s_memh[1] && !mem_wr[RW+1];
        e_stall = (e_data || e_md) && id_valid && !flush;
        e_noop  = e_stall || flush;
        e_acc   = id_valid && !e_stall && !flush;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_dest <= 0; m_fa <= 0; m_fb <= 0;
            m_hz <= 0; m_run <= 0; m_err <= 1'b0;
        end else begin
            if (m_left > 0) m_left <= m_left - 1;
            if (e_acc && id_ctrl[3] && id_wr[RW] && id_wr[RW-1:0] != '0) begin
                m_left <= MDL;
                m_dest <= int'(id_wr[RW-1:0]);
            end
            m_fa <= !e_acc ? 0 : (s_exh[0] && !ex_wr[RW+1]) ? 2 : s_memh[0] ? 1 : 0;
            m_fb <= !e_acc ? 0 : (s_exh[1] && !ex_wr[RW+1]) ? 2 : s_memh[1] ? 1 : 0;
            m_hz <= !e_stall ? 0 : e_data ? 1 : 2;
            m_run <= e_stall ? ((m_run < MAXS) ? m_run + 1 : MAXS) : 0;
            if (e_stall && m_run + 1 >= MAXS) m_err <= 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("m_fwd_a", int'(fwd_a), m_fa);
        check("m_fwd_b", int'(fwd_b), m_fb);
        check("m_fwd_c", int'(fwd_c), int'(e_c));
        check("m_fwd_d", int'(fwd_d), int'(e_d));
        check("m_rf_bypass", int'(rf_bypass), int'(e_byp));
        check("m_stall", int'(stall), int'(e_stall));
        check("m_id_noop", int'(id_noop), int'(e_noop));
        check("m_md_busy", int'(md_busy), int'(m_left > 0));
        check("m_hz_state", int'(hz_state), m_hz);
        check("m_stall_err", int'(stall_err), int'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 1'b0; id_srcs = '0; id_ctrl = '0; id_wr = '0;
        ex_wr = '0; mem_wr = '0; wb_wr = '0; flush = 1'b0;
    endtask

    task automatic set_id(bit v, int rs, int rt, logic [3:0] ctrl, bit wr, int dest);
        id_valid = v;
        id_srcs  = {RW'(rt), RW'(rs)};
        id_ctrl  = ctrl;
        id_wr    = {wr, RW'(dest)};
    endtask

    task automatic set_ex(bit mr, bit rw, int d);
        ex_wr = {mr, rw, RW'(d)};
    endtask

    task automatic set_mem(bit mtr, bit rw, int d);
        mem_wr = {mtr, rw, RW'(d)};
    endtask

    task automatic set_wb(bit rw, int d);
        wb_wr = {rw, RW'(d)};
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        nxt(); nxt();
        smp();
        check("rst_fwd_a", int'(fwd_a), 0);
        check("rst_hz", int'(hz_state), 0);
        check("rst_md_busy", int'(md_busy), 0);
        check("rst_err", int'(stall_err), 0);
        nxt(); rst_n = 1'b1;

        // Load-use: lw r5 in EX, add rs=r5 in ID.
        nxt(); set_id(1, 5, 0, C_RS, 1, 6); set_ex(1, 1, 5);
        smp(); check("lu_stall", int'(stall), 1); check("lu_noop", int'(id_noop), 1);
        nxt(); set_ex(0, 0, 0); set_mem(1, 1, 5);
        smp(); check("lu_stall2", int'(stall), 0); check("lu_hz", int'(hz_state), 1);
        nxt(); idle();
        smp(); check("lu_fwd_a", int'(fwd_a), 1); check("lu_hz_idle", int'(hz_state), 0);

        // ALU chain: add r3 in EX, sub r3,r3 in ID; then same through r0.
        nxt(); set_id(1, 3, 3, C_RS | C_RT, 1, 7); set_ex(0, 1, 3);
        smp(); check("alu_stall", int'(stall), 0);
        nxt(); set_id(1, 0, 0, C_RS | C_RT, 1, 7); set_ex(0, 1, 0);
        smp(); check("alu_fwd_a", int'(fwd_a), 2); check("alu_fwd_b", int'(fwd_b), 2);
        nxt(); idle();
        smp(); check("r0_fwd_a", int'(fwd_a), 0); check("r0_fwd_b", int'(fwd_b), 0);

        // Branch after add r4.
        nxt(); set_id(1, 4, 1, C_BR | C_RS | C_RT, 0, 0); set_ex(0, 1, 4);
        smp(); check("bra_stall", int'(stall), 1); check("bra_fwd_c0", int'(fwd_c), 0);
        nxt(); set_ex(0, 0, 0); set_mem(0, 1, 4);
        smp(); check("bra_stall2", int'(stall), 0); check("bra_fwd_c", int'(fwd_c), 1);
        nxt(); idle();

        // Branch after lw r4: two stall cycles, never fwd_c, then RF write-through.
        nxt(); set_id(1, 4, 1, C_BR | C_RS | C_RT, 0, 0); set_ex(1, 1, 4);
        smp(); check("brl_stall1", int'(stall), 1);
        nxt(); set_ex(0, 0, 0); set_mem(1, 1, 4);
        smp(); check("brl_stall2", int'(stall), 1); check("brl_fwd_c", int'(fwd_c), 0);
        nxt(); set_mem(0, 0, 0); set_wb(1, 4);
        smp(); check("brl_stall3", int'(stall), 0); check("brl_byp", int'(rf_bypass), 1);
        nxt(); idle();

        // MUL/DIV: mult to r8, then a user of r8; 4 stall cycles trip the watchdog.
        nxt(); set_id(1, 1, 2, C_MD | C_RS | C_RT, 1, 8);
        smp(); check("md_issue_stall", int'(stall), 0); check("md_busy0", int'(md_busy), 0);
        nxt(); set_id(1, 8, 0, C_RS, 1, 9);
        for (int k = 0; k < 4; k++) begin
            smp();
            check("md_busy_win", int'(md_busy), 1);
            check("md_stall_win", int'(stall), 1);
            if (k == 1) check("md_hz", int'(hz_state), 2);
            nxt();
        end
        smp();
        check("md_release_stall", int'(stall), 0);
        check("md_release_busy", int'(md_busy), 0);
        check("wd_err_sticky", int'(stall_err), 1);

        // Second md_issue while busy stalls.
        nxt(); set_id(1, 1, 0, C_MD | C_RS, 1, 8);
        nxt(); set_id(1, 2, 0, C_MD | C_RS, 1, 10);
        smp(); check("md2_stall", int'(stall), 1); check("md2_busy", int'(md_busy), 1);
        nxt(); idle();
        repeat (6) nxt();

        // Flush during load-use clears the stall and the forwarding regs.
        set_id(1, 3, 0, C_RS, 1, 7); set_ex(0, 1, 3);
        nxt(); set_id(1, 5, 0, C_RS, 1, 6); set_ex(1, 1, 5); flush = 1'b1;
        smp(); check("fl_fwd_a_prev", int'(fwd_a), 2);
        check("fl_stall", int'(stall), 0); check("fl_noop", int'(id_noop), 1);
        nxt(); idle();
        smp(); check("fl_fwd_a", int'(fwd_a), 0); check("fl_hz", int'(hz_state), 0);

        // Reset in the middle of an MD op.
        nxt(); set_id(1, 1, 0, C_MD | C_RS, 1, 8);
        nxt(); set_id(1, 8, 0, C_RS, 1, 9);
        smp(); check("rm_stall_pre", int'(stall), 1); check("rm_busy_pre", int'(md_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rm_busy", int'(md_busy), 0); check("rm_stall", int'(stall), 0);
        check("rm_noop", int'(id_noop), 0); check("rm_err", int'(stall_err), 0);
        check("rm_hz", int'(hz_state), 0); check("rm_fwd_a", int'(fwd_a), 0);
        nxt(); rst_n = 1'b1;
        smp(); check("rm_after_stall", int'(stall), 0); check("rm_after_busy", int'(md_busy), 0);

        // Randomized traffic over a small register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            nxt();
            id_valid = ($urandom_range(0, 9) < 8);
            id_ctrl  = {($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1)};
            id_srcs  = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
            id_wr    = {($urandom_range(0, 3) != 0), RW'($urandom_range(0, 7))};
            set_ex(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)));
            set_mem(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)));
            set_wb(($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)));
            flush = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        nxt(); idle();
        smp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
